seg7_scan_driver: RTL and testbench

- Responder end of the display write interface: accepts single-cycle register writes (address, data, write strobe) from a display controller into a 4-entry digit store.
- Time-multiplexes the stored digits onto an 8-anode common-anode seven-segment display.
- Inserts an all-off blanking interval at every digit change to suppress ghosting.
- Sits between the display controller and the board pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_driver_if.sv | 9 +
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// The segment table is active-low, bit 6 = a down to bit 0 = g.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_e;

  typedef struct packed {
    logic       dp;
    logic       en;
    logic [3:0] val;
  } digit_entry_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    return HEX_SEG[v];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display write bus: single-cycle register writes from the controller.
interface seg7_scan_driver_if;
  logic [1:0] waddr;
  logic [5:0] wdata;
  logic       we;

  modport master (output waddr, output wdata, output we);
  modport slave  (input  waddr, input  wdata, input  we);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern
  always_comb begin
    seg_o = hex_to_seg(val_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit store with a blank/on scan FSM driving an 8-anode common-anode
// display; all pins are registered and lag the FSM and store by one cycle.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_driver_if.slave    wr,
  output logic [7:0]           E,
  output logic [6:0]           CA2G,
  output logic                 dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  // Prescaler restarts at every state entry, so ON ends after its own length.
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] ON_LAST    = PW'(REFRESH_DIV - BLANK_CYCLES - 1);

  digit_entry_t  store_q [4];
  digit_entry_t  store_d [4];
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q,   idx_d;
  logic [7:0]    e_q,     e_d;
  logic [6:0]    ca_q,    ca_d;
  logic          dp_q,    dp_d;

  digit_entry_t  cur_s;
  logic [6:0]    seg_s;

  assign cur_s = store_q[idx_q];

  seg7_hex_decode u_dec (
    .val_i (cur_s.val),
    .seg_o (seg_s)
  );

  // Digit store write port
  always_comb begin
    store_d = store_q;
    if (wr.we) begin
      store_d[wr.waddr] = digit_entry_t'(wr.wdata);
    end else begin
      store_d = store_q;
    end
  end

  // Scan FSM next state
  always_comb begin
    state_d = state_q;
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    case (state_q)
      BLANK: begin
        if (presc_q == BLANK_LAST) begin
          state_d = ON;
          presc_d = '0;
        end else begin
          state_d = BLANK;
        end
      end
      ON: begin
        if (presc_q == ON_LAST) begin
          state_d = BLANK;
          presc_d = '0;
          idx_d   = idx_q + 2'd1;
        end else begin
          state_d = ON;
        end
      end
      default: begin
        state_d = BLANK;
        presc_d = '0;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Pin values for the current FSM position
  always_comb begin
    e_d  = AN_OFF;
    ca_d = SEG_OFF;
    dp_d = 1'b1;
    if (state_q == ON && cur_s.en) begin
      e_d  = ~(8'h01 << idx_q);
      ca_d = seg_s;
      dp_d = ~cur_s.dp;
    end else begin
      e_d  = AN_OFF;
      ca_d = SEG_OFF;
      dp_d = 1'b1;
    end
  end

  // State, store and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        store_q[i] <= '0;
      end
      state_q <= BLANK;
      presc_q <= '0;
      idx_q   <= 2'd0;
      e_q     <= AN_OFF;
      ca_q    <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      store_q <= store_d;
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      ca_q    <= ca_d;
      dp_q    <= dp_d;
    end
  end

  assign E    = e_q;
  assign CA2G = ca_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a slot-arithmetic reference model
// checked every cycle, plus literal pin expectations at chosen edges.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int RD = 8;
  localparam int BL = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] E;
  logic [6:0] CA2G;
  logic       dp;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (bus.slave),
    .E     (E),
    .CA2G  (CA2G),
    .dp    (dp)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // pos = number of edges since reset; slot = pos/RD, first BL cycles blank
  function automatic logic [15:0] pins_for(input int pos, input logic [5:0] ent);
    int off;
    int dig;
    logic [7:0] an;
    off = pos % RD;
    dig = (pos / RD) % 4;
    an  = 8'h01;
    an  = ~(an << dig);
    if (off < BL || !ent[4]) return {8'hFF, 7'h7F, 1'b1};
    return {an, seg_ref(ent[3:0]), ~ent[5]};
  endfunction

  int          m_edges;
  logic [5:0]  m_store [4];
  logic [15:0] exp_pins;

  // Reference model: pins after an edge reflect position/store before it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges  <= 0;
      exp_pins <= {8'hFF, 7'h7F, 1'b1};
      for (int i = 0; i < 4; i++) m_store[i] <= 6'h00;
    end else begin
      exp_pins <= pins_for(m_edges, m_store[(m_edges / RD) % 4]);
      m_edges  <= m_edges + 1;
      if (bus.we) m_store[bus.waddr] <= bus.wdata;
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    checks++;
    if ({E, CA2G, dp} !== exp_pins) begin
      errors++;
      $display("FAIL model edge=%0d: got E=%h CA2G=%b dp=%b, want E=%h CA2G=%b dp=%b",
               m_edges, E, CA2G, dp, exp_pins[15:8], exp_pins[7:1], exp_pins[0]);
    end
  end

  task automatic chk(input string name, input logic [7:0] e, input logic [6:0] ca, input logic d);
    checks++;
    if (E !== e || CA2G !== ca || dp !== d) begin
      errors++;
      $display("FAIL %s: got E=%h CA2G=%b dp=%b, want E=%h CA2G=%b dp=%b",
               name, E, CA2G, dp, e, ca, d);
    end
  endtask

  task automatic wait_until(input int k);
    int guard;
    guard = 0;
    while (m_edges != k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (m_edges != k) begin
      checks++;
      errors++;
      $display("FAIL timeout: edge count %0d, want %0d", m_edges, k);
    end
  endtask

  task automatic write_at(input int k, input logic [1:0] a, input logic [5:0] d);
    wait_until(k - 1);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic check_at(input int k, input string name, input logic [7:0] e,
                          input logic [6:0] ca, input logic d);
    wait_until(k);
    chk(name, e, ca, d);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.we    = 1'b0;
    bus.waddr = 2'd0;
    bus.wdata = 6'h00;
    repeat (3) @(negedge clk);
    chk("reset_idle", 8'hFF, 7'h7F, 1'b1);
    rst_n = 1'b1;

    write_at(1, 2'd0, 6'h13);
    write_at(2, 2'd1, 6'h3A);
    write_at(3, 2'd2, 6'h10);
    write_at(4, 2'd3, 6'h1F);

    check_at(33, "blank0_a", 8'hFF, 7'h7F, 1'b1);
    check_at(34, "blank0_b", 8'hFF, 7'h7F, 1'b1);
    check_at(35, "digit0",   8'hFE, 7'b0000110, 1'b1);
    check_at(43, "digit1",   8'hFD, 7'b0001000, 1'b0);
    check_at(51, "digit2",   8'hFB, 7'b0000001, 1'b1);
    check_at(59, "digit3",   8'hF7, 7'b0111000, 1'b1);

    write_at(61, 2'd2, 6'h08);
    check_at(75, "d1_after_dis", 8'hFD, 7'b0001000, 1'b0);
    check_at(83, "digit2_dis",   8'hFF, 7'h7F, 1'b1);
    check_at(90, "digit2_dis_end", 8'hFF, 7'h7F, 1'b1);
    check_at(91, "d3_after_dis", 8'hF7, 7'b0111000, 1'b1);

    write_at(100, 2'd0, 6'h15);
    check_at(100, "live_old", 8'hFE, 7'b0000110, 1'b1);
    check_at(101, "live_new", 8'hFE, 7'b0100100, 1'b1);

    write_at(136, 2'd1, 6'h17);
    check_at(138, "adv_blank", 8'hFF, 7'h7F, 1'b1);
    check_at(139, "adv_new",   8'hFD, 7'b0001111, 1'b1);

    check_at(155, "pre_rst", 8'hF7, 7'b0111000, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 8'hFF, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    write_at(1, 2'd0, 6'h13);
    check_at(2, "rel_blank", 8'hFF, 7'h7F, 1'b1);
    check_at(3, "rel_first", 8'hFE, 7'b0000110, 1'b1);
    check_at(8, "rel_last",  8'hFE, 7'b0000110, 1'b1);
    check_at(9, "rel_next",  8'hFF, 7'h7F, 1'b1);
    check_at(11, "rel_d1_dis", 8'hFF, 7'h7F, 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
